// File: rtl/eth_rx_frame_parser.sv
// Ethernet receive byte parser: strips preamble/SFD, captures the header,
// filters on destination address, forwards payload without FCS, reports CRC/length status.
module eth_rx_frame_parser #(
    parameter logic [47:0] MAC_ADDRESS  = 48'h11_22_33_44_55_66,
    parameter bit          PROMISCUOUS  = 1'b0,
    parameter bit          SWAP_NIBBLES = 1'b1,
    parameter int          MIN_FRAME    = 64,
    parameter int          MAX_FRAME    = 1518
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        header_valid,
    output logic [47:0] dest_mac,
    output logic [47:0] src_mac,
    output logic [15:0] ethertype,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        frame_done,
    output logic        frame_ok,
    output logic        crc_error,
    output logic        length_error,
    output logic        addr_match,
    output logic [10:0] frame_length
);

    // state    | meaning
    // S_IDLE     | waiting for first preamble byte
    // S_PREAMBLE | 0x55 run, waiting for SFD
    // S_HEADER   | dest/src/type bytes 0-13
    // S_PAYLOAD  | payload through 4-byte FCS delay line
    // S_DROP     | discarding until in_last
    typedef enum logic [2:0] {S_IDLE, S_PREAMBLE, S_HEADER, S_PAYLOAD, S_DROP} state_t;

    localparam logic [10:0] MIN_LEN = 11'(MIN_FRAME);
    localparam logic [10:0] MAX_LEN = 11'(MAX_FRAME);
    localparam logic [31:0] RESIDUE = 32'hDEBB_20E3;

    state_t      state, state_next;
    logic [7:0]  b;
    logic [31:0] crc, crc_next;
    logic [10:0] count, count_inc;
    logic [47:0] dest_sh, src_sh;
    logic [7:0]  type_hi;
    logic [31:0] line;
    logic [2:0]  fill;
    logic        match_int, match_now;
    logic        start, hdr_fire, done_fire, in_frame;
    logic        crc_bad, len_bad;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    assign b         = SWAP_NIBBLES ? {in_data[3:0], in_data[7:4]} : in_data;
    assign crc_next  = crc_byte(crc, b);
    assign count_inc = (count == 11'h7FF) ? count : count + 11'd1;
    assign in_frame  = in_valid && (state == S_HEADER || state == S_PAYLOAD);
    assign crc_bad   = (crc_next != RESIDUE);
    assign len_bad   = (count_inc < MIN_LEN) || (count_inc > MAX_LEN);
    // Address decision is made on the sixth header byte, before it lands in dest_sh.
    assign match_now = (state == S_HEADER && count == 11'd5)
                     ? (({dest_sh[39:0], b} == MAC_ADDRESS) ||
                        ({dest_sh[39:0], b} == 48'hFFFF_FFFF_FFFF) || PROMISCUOUS)
                     : match_int;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        hdr_fire   = 1'b0;
        done_fire  = 1'b0;
        if (in_valid) begin
            case (state)
                S_IDLE:
                    if (!in_last) state_next = (b == 8'h55) ? S_PREAMBLE : S_DROP;
                S_PREAMBLE:
                    if (in_last)           state_next = S_IDLE;
                    else if (b == 8'hD5) begin
                        state_next = S_HEADER;
                        start      = 1'b1;
                    end
                    else if (b != 8'h55)   state_next = S_DROP;
                S_HEADER:
                    if (in_last) begin
                        done_fire  = 1'b1;
                        state_next = S_IDLE;
                    end else if (count == 11'd13) begin
                        hdr_fire   = 1'b1;
                        state_next = S_PAYLOAD;
                    end
                S_PAYLOAD:
                    if (in_last) begin
                        done_fire  = 1'b1;
                        state_next = S_IDLE;
                    end
                S_DROP:
                    if (in_last) state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            header_valid <= 1'b0;
            dest_mac     <= '0;
            src_mac      <= '0;
            ethertype    <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            frame_done   <= 1'b0;
            frame_ok     <= 1'b0;
            crc_error    <= 1'b0;
            length_error <= 1'b0;
            addr_match   <= 1'b0;
            frame_length <= '0;
            crc          <= '1;
            count        <= '0;
            dest_sh      <= '0;
            src_sh       <= '0;
            type_hi      <= '0;
            line         <= '0;
            fill         <= '0;
            match_int    <= 1'b0;
        end else begin
            header_valid <= hdr_fire;
            frame_done   <= done_fire;
            out_valid    <= 1'b0;
            if (start) begin
                crc       <= '1;
                count     <= '0;
                fill      <= '0;
                match_int <= 1'b0;
            end
            if (in_frame) begin
                crc   <= crc_next;
                count <= count_inc;
                if (state == S_HEADER) begin
                    match_int <= match_now;
                    if (count < 11'd6)       dest_sh <= {dest_sh[39:0], b};
                    else if (count < 11'd12) src_sh  <= {src_sh[39:0], b};
                    else                     type_hi <= b;
                end else begin
                    line <= {line[23:0], b};
                    if (fill == 3'd4) begin
                        out_valid <= match_int;
                        out_data  <= line[31:24];
                    end else begin
                        fill <= fill + 3'd1;
                    end
                end
            end
            if (hdr_fire) begin
                dest_mac  <= dest_sh;
                src_mac   <= src_sh;
                ethertype <= {type_hi, b};
            end
            if (done_fire) begin
                crc_error    <= crc_bad;
                length_error <= len_bad;
                addr_match   <= match_now;
                frame_ok     <= !crc_bad && !len_bad && match_now;
                frame_length <= count_inc;
            end
        end
    end

endmodule

// File: tb/tb_eth_rx_frame_parser.sv
// Bench for eth_rx_frame_parser: fixed vector table, randomized frames against a
// stream-level reference model, and a mid-frame reset sequence.
module tb_eth_rx_frame_parser;

    typedef logic [7:0] bq_t[$];

    localparam logic [47:0] STN = 48'h11_22_33_44_55_66;
    localparam logic [47:0] BC  = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] SRC = 48'h02_00_00_00_00_01;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_last = 1'b0;
    logic        header_valid, out_valid, frame_done, frame_ok;
    logic        crc_error, length_error, addr_match;
    logic [47:0] dest_mac, src_mac;
    logic [15:0] ethertype;
    logic [7:0]  out_data;
    logic [10:0] frame_length;

    eth_rx_frame_parser dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .header_valid(header_valid), .dest_mac(dest_mac),
        .src_mac(src_mac), .ethertype(ethertype), .out_valid(out_valid),
        .out_data(out_data), .frame_done(frame_done), .frame_ok(frame_ok),
        .crc_error(crc_error), .length_error(length_error), .addr_match(addr_match),
        .frame_length(frame_length)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    int          hv_cnt = 0, done_cnt = 0, both_cnt = 0;
    logic [47:0] cap_dest = '0, cap_src = '0;
    logic [15:0] cap_type = '0;
    logic        cap_ok = 0, cap_crc = 0, cap_lerr = 0, cap_match = 0;
    logic [10:0] cap_len = '0;
    bq_t         out_q;

    always @(negedge clock) begin
        if (!reset) begin
            if (header_valid) begin
                hv_cnt   <= hv_cnt + 1;
                cap_dest <= dest_mac;
                cap_src  <= src_mac;
                cap_type <= ethertype;
            end
            if (out_valid) out_q.push_back(out_data);
            if (frame_done) begin
                done_cnt  <= done_cnt + 1;
                cap_ok    <= frame_ok;
                cap_crc   <= crc_error;
                cap_lerr  <= length_error;
                cap_match <= addr_match;
                cap_len   <= frame_length;
            end
            if (header_valid && frame_done) both_cnt <= both_cnt + 1;
        end
    end

    typedef struct {
        bit          done, hdr, ok, crc, lerr, match;
        int          npay, flen;
        logic [47:0] dest, src;
        logic [15:0] etype;
    } exp_t;

    typedef struct {
        logic [47:0] dest;
        int          plen;
        logic [7:0]  sfd;
        int          trunc;
        bit          corrupt, gaps;
        bit          e_done, e_hdr;
        int          e_npay;
        bit          e_ok, e_crc, e_lerr, e_match;
        int          e_flen;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] crc32(input bq_t f, input int len);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < len; i++) begin
            c = c ^ {24'd0, f[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic build_frame(input logic [47:0] d, input int plen, input bit rnd, output bq_t f);
        logic [31:0] c;
        f = {};
        for (int i = 0; i < 6; i++) f.push_back(d[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) f.push_back(SRC[47-8*i -: 8]);
        f.push_back(8'h08);
        f.push_back(8'h00);
        for (int i = 0; i < plen; i++) f.push_back(rnd ? 8'($urandom) : 8'(i));
        c = crc32(f, f.size());
        for (int i = 0; i < 4; i++) f.push_back(c[8*i +: 8]);
    endtask

    // Reference: interpret a whole in_last-terminated byte stream by the framing rules.
    task automatic model(input bq_t s, output exp_t e, output bq_t pay);
        int i, n;
        bq_t f;
        logic [31:0] fcs;
        logic [47:0] d;
        e = '{default: 0};
        pay = {};
        if (s.size() < 2 || s[0] != 8'h55) return;
        i = 0;
        while (i < s.size() - 1 && s[i] == 8'h55) i++;
        if (i == s.size() - 1 || s[i] != 8'hD5) return;
        for (int j = i + 1; j < s.size(); j++) f.push_back(s[j]);
        n = f.size();
        e.done = 1;
        e.flen = (n > 2047) ? 2047 : n;
        e.lerr = (e.flen < 64) || (e.flen > 1518);
        if (n >= 6) begin
            d = {f[0], f[1], f[2], f[3], f[4], f[5]};
            e.match = (d == STN) || (d == BC);
            e.dest = d;
        end
        e.crc = 1;
        if (n >= 4) begin
            fcs = {f[n-1], f[n-2], f[n-3], f[n-4]};
            e.crc = (crc32(f, n - 4) != fcs);
        end
        e.ok = !e.crc && !e.lerr && e.match;
        e.hdr = (n >= 15);
        if (e.hdr) begin
            e.src   = {f[6], f[7], f[8], f[9], f[10], f[11]};
            e.etype = {f[12], f[13]};
            if (e.match) for (int j = 14; j < n - 4; j++) pay.push_back(f[j]);
        end
        e.npay = pay.size();
    endtask

    task automatic send_bytes(input bq_t s, input int lo, input int hi, input bit mark_last,
                              input bit gaps);
        for (int i = lo; i < hi; i++) begin
            if (gaps) repeat ($urandom_range(0, 5)) begin
                @(negedge clock);
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            @(negedge clock);
            in_valid = 1'b1;
            in_data  = {s[i][3:0], s[i][7:4]};
            in_last  = mark_last && (i == hi - 1);
        end
        @(negedge clock);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_check(input string tag, input bq_t s, input bit gaps, input exp_t e,
                             input bq_t pay);
        int hv0, dn0, pq0, bad;
        hv0 = hv_cnt;
        dn0 = done_cnt;
        pq0 = out_q.size();
        send_bytes(s, 0, s.size(), 1'b1, gaps);
        repeat (4) @(negedge clock);
        check({tag, "_done_count"}, done_cnt - dn0, e.done);
        check({tag, "_hdr_count"}, hv_cnt - hv0, e.hdr);
        if (e.hdr) begin
            check({tag, "_dest_mac"}, cap_dest, e.dest);
            check({tag, "_src_mac"}, cap_src, e.src);
            check({tag, "_ethertype"}, cap_type, e.etype);
        end
        check({tag, "_payload_count"}, out_q.size() - pq0, e.npay);
        bad = 0;
        if (out_q.size() - pq0 == pay.size())
            for (int i = 0; i < pay.size(); i++) if (out_q[pq0 + i] !== pay[i]) bad++;
        check({tag, "_payload_bad_bytes"}, bad, 0);
        if (e.done) begin
            check({tag, "_frame_ok"}, cap_ok, e.ok);
            check({tag, "_crc_error"}, cap_crc, e.crc);
            check({tag, "_length_error"}, cap_lerr, e.lerr);
            check({tag, "_addr_match"}, cap_match, e.match);
            check({tag, "_frame_length"}, cap_len, e.flen);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_flags"}, {header_valid, out_valid, frame_done, frame_ok,
                               crc_error, length_error, addr_match}, 0);
        check({tag, "_dest_mac"}, dest_mac, 0);
        check({tag, "_src_mac"}, src_mac, 0);
        check({tag, "_type_data_len"}, {ethertype, out_data, frame_length}, 0);
    endtask

    task automatic with_preamble(input int pre, input logic [7:0] sfd, input bq_t f,
                                 output bq_t s);
        s = {};
        repeat (pre) s.push_back(8'h55);
        s.push_back(sfd);
        foreach (f[i]) s.push_back(f[i]);
    endtask

    initial begin
        vec_t vt[12];
        bq_t  f, s, pay;
        exp_t e, em;
        int   hv0, dn0, pq0, r;
        logic [47:0] d;

        vt[0]  = '{STN,   46, 8'hD5,  0, 0, 0, 1, 1,   46, 1, 0, 0, 1,   64};
        vt[1]  = '{STN,   46, 8'hD5,  0, 1, 0, 1, 1,   46, 0, 1, 0, 1,   64};
        vt[2]  = '{48'h7, 46, 8'hD5,  0, 0, 0, 1, 1,    0, 0, 0, 0, 0,   64};
        vt[3]  = '{BC,    46, 8'hD5,  0, 0, 0, 1, 1,   46, 1, 0, 0, 1,   64};
        vt[4]  = '{STN,   46, 8'hD5, 10, 0, 0, 1, 0,    0, 0, 1, 1, 1,   10};
        vt[5]  = '{STN, 1501, 8'hD5,  0, 0, 0, 1, 1, 1501, 0, 0, 1, 1, 1519};
        vt[6]  = '{STN,   46, 8'h5A, 20, 0, 0, 0, 0,    0, 0, 0, 0, 0,    0};
        vt[7]  = '{STN,   46, 8'hD5,  0, 0, 0, 1, 1,   46, 1, 0, 0, 1,   64};
        vt[8]  = '{STN,   46, 8'hD5,  0, 0, 1, 1, 1,   46, 1, 0, 0, 1,   64};
        vt[9]  = '{STN, 1500, 8'hD5,  0, 0, 0, 1, 1, 1500, 1, 0, 0, 1, 1518};
        vt[10] = '{STN,   45, 8'hD5,  0, 0, 0, 1, 1,   45, 0, 0, 1, 1,   63};
        vt[11] = '{STN, 2082, 8'hD5,  0, 0, 0, 1, 1, 2082, 0, 0, 1, 1, 2047};

        repeat (3) @(negedge clock);
        check_all_zero("reset_state");
        reset = 1'b0;
        @(negedge clock);

        for (int k = 0; k < 12; k++) begin
            build_frame(vt[k].dest, vt[k].plen, 1'b0, f);
            if (vt[k].corrupt) f[f.size()-1] = f[f.size()-1] ^ 8'h01;
            if (vt[k].trunc > 0) while (f.size() > vt[k].trunc) void'(f.pop_back());
            with_preamble(7, vt[k].sfd, f, s);
            model(s, em, pay);
            e = '{default: 0};
            e.done  = vt[k].e_done;  e.hdr  = vt[k].e_hdr;  e.npay  = vt[k].e_npay;
            e.ok    = vt[k].e_ok;    e.crc  = vt[k].e_crc;  e.lerr  = vt[k].e_lerr;
            e.match = vt[k].e_match; e.flen = vt[k].e_flen;
            e.dest  = vt[k].dest;    e.src  = SRC;          e.etype = 16'h0800;
            run_check($sformatf("vec%0d", k), s, vt[k].gaps, e, pay);
        end

        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 3);
            d = (r == 0) ? STN : (r == 1) ? BC : (r == 2) ? {$urandom, $urandom} :
                (STN ^ (48'h1 << $urandom_range(0, 47)));
            build_frame(d, $urandom_range(0, 90), 1'b1, f);
            if ($urandom_range(0, 5) == 0) begin
                r = $urandom_range(0, f.size() - 1);
                f[r] = f[r] ^ 8'(1 << $urandom_range(0, 7));
            end
            if ($urandom_range(0, 5) == 0) begin
                r = $urandom_range(4, f.size());
                while (f.size() > r) void'(f.pop_back());
            end
            with_preamble($urandom_range(1, 8),
                          ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'hD5, f, s);
            if ($urandom_range(0, 9) == 0) s[0] = 8'($urandom);
            model(s, e, pay);
            run_check($sformatf("rnd%0d", k), s, 1'($urandom_range(0, 1)), e, pay);
        end

        build_frame(STN, 46, 1'b0, f);
        with_preamble(7, 8'hD5, f, s);
        send_bytes(s, 0, 42, 1'b0, 1'b0);
        check("pre_reset_hdr_seen", cap_dest, STN);
        reset = 1'b1;
        @(negedge clock);
        check_all_zero("mid_reset");
        reset = 1'b0;
        hv0 = hv_cnt;
        dn0 = done_cnt;
        pq0 = out_q.size();
        send_bytes(s, 42, s.size(), 1'b1, 1'b0);
        repeat (4) @(negedge clock);
        check("after_reset_tail_done", done_cnt - dn0, 0);
        check("after_reset_tail_hdr", hv_cnt - hv0, 0);
        check("after_reset_tail_out", out_q.size() - pq0, 0);
        model(s, e, pay);
        run_check("post_reset_good", s, 1'b0, e, pay);
        check("post_reset_frame_ok", cap_ok, 1'b1);

        check("hdr_done_overlap", both_cnt, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
